// File: rtl/uart_pkg.sv
// UART receive path shared types: parity mode, receiver FSM states, parity helper.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package uart_pkg;

  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_RSVD = 2'b11
  } parity_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } rx_state_t;

  // Parity bit the transmitter should have sent for 'data' (zero-extended
  // character). Returns 0 when parity is off or the mode is reserved.
  function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data,
                                       input parity_mode_t              mode);
    logic p;
    p = ^data;
    case (mode)
      PAR_EVEN: return p;
      PAR_ODD:  return ~p;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Received-character handshake bundle between the UART receiver and its consumer.
// Latency: n/a (wiring only).
// Backpressure: consumer drives data_ready; producer holds data/status while valid && !ready.
// Ports: data_out, data_valid, parity_err, framing_err, break_det, overrun_err (producer -> consumer);
//        data_ready (consumer -> producer).
interface uart_rx_core_if #(parameter int DATA_BITS = 8);

  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 parity_err;
  logic                 framing_err;
  logic                 break_det;
  logic                 overrun_err;

  modport master (
    output data_out, data_valid, parity_err, framing_err, break_det, overrun_err,
    input  data_ready
  );

  modport slave (
    input  data_out, data_valid, parity_err, framing_err, break_det, overrun_err,
    output data_ready
  );

endinterface

// File: rtl/uart_sync_chain.sv
// Multi-flop synchroniser for asynchronous inputs; flops reset to all-ones (line idle).
// Latency: STAGES clk cycles.
// Backpressure: none.
// Ports: clk, rst_n, i_d (async input), o_q (synchronised output).
module uart_sync_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [STAGES-1:0][WIDTH-1:0] r_stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= '1;
    end else begin
      r_stage <= {r_stage[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// Oversampled UART receiver: start/data/parity/stop detection with configurable frame format.
// Latency: character presented the clk cycle after the final stop-bit mid-sample.
// Backpressure: holds one character on valid/ready; a frame completing while it is unaccepted is dropped (overrun pulse).
// Ports: clk, rst_n, rx_raw, sample_tick, parity_mode, two_stop, busy, rx_if (master handshake + status).
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_raw,
  input  logic                  sample_tick,
  input  logic [1:0]            parity_mode,
  input  logic                  two_stop,
  output logic                  busy,
  uart_rx_core_if.master        rx_if
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  rx_state_t            r_state, w_next;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  parity_mode_t         r_par_mode;
  logic                 r_two_stop, r_par_err, r_framing, r_all_zero;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_pe, r_fe, r_brk, r_ovr;
  logic                 w_rx_s, w_mid, w_end, w_par_en;
  logic                 w_start_det, w_sample, w_commit, w_busy, w_hold;

  uart_sync_chain #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rx_raw),
    .o_q   (w_rx_s)
  );

  assign w_mid    = (r_cnt == CNT_MID);
  assign w_end    = (r_cnt == CNT_END);
  assign w_par_en = (r_par_mode == PAR_EVEN) || (r_par_mode == PAR_ODD);
  assign w_hold   = r_valid & ~rx_if.data_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; every transition after START happens on a mid-bit tick
  always_comb begin
    w_next = r_state;
    if (sample_tick) begin
      case (r_state)
        ST_IDLE:   if (!w_rx_s) w_next = ST_START;
        ST_START:  if (w_mid) w_next = w_rx_s ? ST_IDLE : ST_DATA;
        ST_DATA:   if (w_end && r_bit_cnt == LAST_BIT) w_next = w_par_en ? ST_PARITY : ST_STOP1;
        ST_PARITY: if (w_end) w_next = ST_STOP1;
        ST_STOP1:  if (w_end) w_next = r_two_stop ? ST_STOP2 : ST_IDLE;
        ST_STOP2:  if (w_end) w_next = ST_IDLE;
        default:   w_next = ST_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    w_start_det = 1'b0;
    w_sample    = 1'b0;
    w_commit    = 1'b0;
    w_busy      = (r_state != ST_IDLE);
    if (sample_tick) begin
      w_start_det = (r_state == ST_IDLE) && !w_rx_s;
      w_sample    = w_end && (r_state inside {ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2});
      w_commit    = w_end && (((r_state == ST_STOP1) && !r_two_stop) || (r_state == ST_STOP2));
    end
  end

  // Tick counter and frame datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_mode <= PAR_NONE;
      r_two_stop <= 1'b0;
      r_par_err  <= 1'b0;
      r_framing  <= 1'b0;
      r_all_zero <= 1'b0;
    end else if (sample_tick) begin
      case (r_state)
        ST_IDLE:  r_cnt <= '0;
        ST_START: r_cnt <= w_mid ? '0 : r_cnt + CW'(1);
        default:  r_cnt <= w_end ? '0 : r_cnt + CW'(1);
      endcase
      if (w_start_det) begin
        // Frame format is frozen for the whole frame at start detection
        r_par_mode <= parity_mode_t'(parity_mode);
        r_two_stop <= two_stop;
        r_bit_cnt  <= '0;
        r_par_err  <= 1'b0;
        r_framing  <= 1'b0;
        r_all_zero <= 1'b1;
      end
      if (w_sample) begin
        r_all_zero <= r_all_zero & ~w_rx_s;
        case (r_state)
          ST_DATA: begin
            r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + BW'(1);
          end
          ST_PARITY: r_par_err <= (w_rx_s != parity_calc(MAX_DATA_BITS'(r_shift), r_par_mode));
          default:   r_framing <= r_framing | ~w_rx_s;
        endcase
      end
    end
  end

  // Output register; the final stop sample is folded in combinationally at commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_pe    <= 1'b0;
      r_fe    <= 1'b0;
      r_brk   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= w_commit & w_hold;
      if (w_commit && !w_hold) begin
        r_data  <= r_shift;
        r_pe    <= r_par_err;
        r_fe    <= r_framing | ~w_rx_s;
        r_brk   <= r_all_zero & ~w_rx_s;
        r_valid <= 1'b1;
      end else if (r_valid && rx_if.data_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign busy              = w_busy;
  assign rx_if.data_out    = r_data;
  assign rx_if.data_valid  = r_valid;
  assign rx_if.parity_err  = r_pe;
  assign rx_if.framing_err = r_fe;
  assign rx_if.break_det   = r_brk;
  assign rx_if.overrun_err = r_ovr;

endmodule

// File: tb/tb_uart_rx_core.sv
`timescale 1ns/1ps
module tb_uart_rx_core;
  import uart_pkg::*;

  localparam int OS       = 16;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = OS * TICK_DIV;
  // Ticks from the first tick after busy rises to the commit tick, 8N1:
  // half a bit to the start mid-point, then 8 data bits and one stop bit.
  localparam int K_COMMIT = OS/2 + OS*(8 + 1);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx8 = 1'b1;
  logic       rx5 = 1'b1;
  logic       sample_tick = 1'b0;
  logic       two_stop = 1'b0;
  logic [1:0] parity_mode = 2'b00;
  logic       busy8, busy5;
  int         tests = 0;
  int         fails = 0;
  int         div = 0;
  int         hs_cnt = 0;
  int         ovr_cnt = 0;

  uart_rx_core_if #(.DATA_BITS(8)) if8();
  uart_rx_core_if #(.DATA_BITS(5)) if5();

  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(OS), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .rx_raw(rx8), .sample_tick(sample_tick),
    .parity_mode(parity_mode), .two_stop(two_stop), .busy(busy8), .rx_if(if8)
  );

  uart_rx_core #(.DATA_BITS(5), .OVERSAMPLE(OS), .SYNC_STAGES(3)) dut5 (
    .clk(clk), .rst_n(rst_n), .rx_raw(rx5), .sample_tick(sample_tick),
    .parity_mode(parity_mode), .two_stop(two_stop), .busy(busy5), .rx_if(if5)
  );

  always #5 clk = ~clk;

  // One-cycle sample_tick every TICK_DIV clocks, changed on the falling edge
  initial forever begin
    @(negedge clk);
    div = (div + 1) % TICK_DIV;
    sample_tick = (div == 0);
  end

  typedef struct {
    logic [7:0] d;
    logic       pe, fe, brk;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [7:0] d;
    logic [1:0] pm;
    logic       pb, s1, ts, s2;
    logic       epe, efe, ebrk;
  } vec_t;
  vec_t vt[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic pe, input logic fe, input logic brk);
    exp_t e;
    e.d = d; e.pe = pe; e.fe = fe; e.brk = brk;
    sb.push_back(e);
  endtask

  task automatic drive_bit(input bit to5, input logic b);
    if (to5) rx5 = b;
    else     rx8 = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input bit to5, input logic [8:0] d, input int nb,
                            input bit has_par, input logic pb, input logic s1,
                            input bit has_s2, input logic s2);
    drive_bit(to5, 1'b0);
    for (int i = 0; i < nb; i++) drive_bit(to5, d[i]);
    if (has_par) drive_bit(to5, pb);
    drive_bit(to5, s1);
    if (has_s2) drive_bit(to5, s2);
    drive_bit(to5, 1'b1);
    drive_bit(to5, 1'b1);
  endtask

  // Scoreboard: every accepted character is compared with the queue head
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (if8.overrun_err) ovr_cnt++;
    if (rst_n && if8.data_valid && if8.data_ready) begin
      hs_cnt++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_frame: got data %0h with nothing expected", if8.data_out);
      end else begin
        e = sb.pop_front();
        check("frame_data", 32'(if8.data_out), 32'(e.d));
        check("frame_flags", {29'd0, if8.parity_err, if8.framing_err, if8.break_det},
              {29'd0, e.pe, e.fe, e.brk});
      end
    end
  end

  initial begin
    int   o0, h0;
    bit   dropped, got5;
    logic [4:0] d5;
    logic [2:0] f5;

    // fields: d, pm, pb, s1, ts, s2, expected pe, fe, brk
    vt[0]  = '{8'hA5, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{8'h03, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{8'h03, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{8'h5A, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[5]  = '{8'h3C, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{8'h80, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[7]  = '{8'h7E, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{8'hFF, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[9]  = '{8'h00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[10] = '{8'h00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    if8.data_ready = 1'b1;
    if5.data_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_status", {26'd0, if8.data_valid, if8.parity_err, if8.framing_err,
          if8.break_det, if8.overrun_err, busy8}, 32'd0);
    check("reset_data", 32'(if8.data_out), 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Table-driven frames through the 8-bit receiver
    for (int i = 0; i < 11; i++) begin
      parity_mode = vt[i].pm;
      two_stop    = vt[i].ts;
      push(vt[i].d, vt[i].epe, vt[i].efe, vt[i].ebrk);
      send_frame(1'b0, {1'b0, vt[i].d}, 8, (vt[i].pm == 2'b01) || (vt[i].pm == 2'b10),
                 vt[i].pb, vt[i].s1, vt[i].ts, vt[i].s2);
      check("vec_drained", 32'(sb.size()), 32'd0);
    end
    parity_mode = 2'b00;
    two_stop    = 1'b0;

    // Start-bit glitch: low for 6 ticks only
    h0 = hs_cnt;
    rx8 = 1'b0;
    repeat (6 * TICK_DIV) @(negedge clk);
    #1;
    check("glitch_busy_before_mid", 32'(busy8), 32'd1);
    rx8 = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    check("glitch_idle", 32'(busy8), 32'd0);
    check("glitch_no_output", 32'(hs_cnt), 32'(h0));

    // Overrun: ready held low across two frames
    if8.data_ready = 1'b0;
    o0 = ovr_cnt;
    push(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(1'b0, 9'h011, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send_frame(1'b0, 9'h022, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("ovr_hold_valid", 32'(if8.data_valid), 32'd1);
    check("ovr_hold_data", 32'(if8.data_out), 32'h11);
    check("ovr_pulse_count", 32'(ovr_cnt - o0), 32'd1);
    if8.data_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("ovr_drained", 32'(sb.size()), 32'd0);

    // Ready raised exactly in the cycle of the second commit
    if8.data_ready = 1'b0;
    push(8'h11, 1'b0, 1'b0, 1'b0);
    push(8'h22, 1'b0, 1'b0, 1'b0);
    send_frame(1'b0, 9'h011, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    o0 = ovr_cnt;
    dropped = 1'b0;
    fork
      send_frame(1'b0, 9'h022, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      begin : edge_thread
        int k;
        int w;
        k = 0;
        w = 0;
        do begin
          @(negedge clk);
          #1;
          w++;
        end while (!busy8 && w < 4 * BIT_CLKS);
        check("edge_busy_rise", 32'(busy8), 32'd1);
        while (k < K_COMMIT && w < 20 * BIT_CLKS) begin
          if (!if8.data_valid) dropped = 1'b1;
          if (sample_tick) k++;
          if (k == K_COMMIT) begin
            if8.data_ready = 1'b1;
          end else begin
            @(negedge clk);
            #1;
            w++;
          end
        end
        check("edge_ticks_counted", 32'(k), 32'(K_COMMIT));
        @(negedge clk);
        #1;
        check("edge_valid_kept", {30'd0, dropped, if8.data_valid}, 32'd1);
      end
    join
    if8.data_ready = 1'b1;
    check("edge_drained", 32'(sb.size()), 32'd0);
    check("edge_no_overrun", 32'(ovr_cnt - o0), 32'd0);

    // Asynchronous reset in the middle of the data bits
    fork
      send_frame(1'b0, 9'h0C3, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      begin
        repeat (3 * BIT_CLKS) @(negedge clk);
        #1;
        check("rst_mid_busy_before", 32'(busy8), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_status", {26'd0, if8.data_valid, if8.parity_err, if8.framing_err,
              if8.break_det, if8.overrun_err, busy8}, 32'd0);
        check("rst_mid_data", 32'(if8.data_out), 32'd0);
      end
    join
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    push(8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(1'b0, 9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("post_reset_drained", 32'(sb.size()), 32'd0);

    // 5-bit receiver
    got5 = 1'b0;
    d5   = '0;
    f5   = '0;
    fork
      send_frame(1'b1, 9'h01F, 5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      begin
        for (int c = 0; c < 9 * BIT_CLKS; c++) begin
          @(negedge clk);
          #2;
          if (if5.data_valid && !got5) begin
            got5 = 1'b1;
            d5   = if5.data_out;
            f5   = {if5.parity_err, if5.framing_err, if5.break_det};
          end
        end
      end
    join
    check("db5_received", 32'(got5), 32'd1);
    check("db5_data", 32'(d5), 32'h1F);
    check("db5_flags", 32'(f5), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Parametrised UART receive engine: oversampled start/data/parity/stop detection with configurable frame format.
- Delivers each received character on a valid/ready output handshake, with per-frame error status.
- Sits between the raw rx pin and the host-side FIFO/register interface.
- Supersedes the fixed 8N1, 16x bit detector.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
OVERSAMPLE, 16, sample_tick pulses per bit period; even, legal range 4..32.
SYNC_STAGES, 2, flops in the input synchroniser; at least 2.

Ports:
clk  input  1  peripheral clock
rst_n  input  1  asynchronous active-low reset
rx_raw  input  1  asynchronous serial input; idle level is high
sample_tick  input  1  single-cycle enable at baud*OVERSAMPLE
parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none
two_stop  input  1  1 = two stop bits expected
data_out  output  DATA_BITS  received character, LSB first on the line
data_valid  output  1  data_out and status are valid
data_ready  input  1  consumer accepts on data_valid && data_ready
parity_err  output  1  status of the held frame: parity mismatch
framing_err  output  1  status of the held frame: a stop bit sampled low
break_det  output  1  status of the held frame: data, parity and stop all zero
overrun_err  output  1  one-cycle pulse: a completed frame was dropped
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - FSM goes to IDLE and the tick counter clears.
  - Synchroniser flops reset to 1.
  - data_out = 0; data_valid, parity_err, framing_err, break_det, overrun_err and busy = 0.
- Synchroniser: rx_raw passes through SYNC_STAGES flops on clk; all decisions use the synchronised value rx_s.
- Tick counter: width $clog2(OVERSAMPLE); advances only on sample_tick. MID = OVERSAMPLE/2-1, END = OVERSAMPLE-1.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: on sample_tick with rx_s == 0, go to START and clear the counter. parity_mode and two_stop are latched here; changes mid-frame are ignored.
  - START: at the MID tick, if rx_s == 1 the start bit is a glitch and the FSM returns to IDLE with no output. Otherwise the counter re-zeros and the FSM goes to DATA. All later samples fall at mid-bit.
  - DATA: sample every OVERSAMPLE ticks into a shift register, LSB first. After DATA_BITS samples, go to PARITY if parity is enabled, otherwise to STOP1.
  - PARITY: one sample. Error if XOR(data, parity bit) is not 0 for even, or not 1 for odd.
  - STOP1: one sample; low sets the framing flag. If two_stop is latched, go to STOP2; otherwise commit.
  - STOP2: one sample; low sets the framing flag; then commit.
- Commit happens on the clk edge of the final stop sample tick; the FSM returns to IDLE on that same edge.
  - Next start detection begins half a bit early, which tolerates baud mismatch.
  - data_valid rises the cycle after the commit edge.
- Output register:
  - data_out and the three status flags load together at commit.
  - All four hold stable while data_valid is high and data_ready is low.
  - data_valid falls the cycle after a handshake, unless a commit occurs on that same edge; then the new frame loads and data_valid stays high.
- Overrun: a commit while data_valid && !data_ready drops the new frame and keeps the old one. overrun_err pulses high for one cycle.
- break_det: set when all data bits, the parity bit (if enabled) and every stop bit sampled are 0. framing_err is also set for such a frame.
- sample_tick held low freezes the FSM in its current state; it is not an error.

Decomposition:
- Package uart_pkg holds:
  - parity_mode_t enum (PAR_NONE, PAR_EVEN, PAR_ODD, PAR_RSVD);
  - rx_state_t enum;
  - the function parity_calc(data, mode).
- One sub-module: uart_sync_chain, parametrised by width and SYNC_STAGES, with reset value 1. It replaces the fixed two-flop synchroniser.
- FSM, counters and output register live in uart_rx_core.

Test Plan:
- 8N1, OVERSAMPLE=16, byte 0xA5, data_ready tied high -> one data_valid pulse with data_out = 0xA5; all error flags 0.
- Even parity with 0x03 sent and parity bit 1 (wrong) -> data_out = 0x03, parity_err = 1. Same byte with parity bit 0 -> parity_err = 0.
- Line low for 6 ticks, then high (glitch) -> FSM back in IDLE, no data_valid, busy drops after the MID tick.
- two_stop=1 with second stop bit driven low on 0x5A -> data_out = 0x5A, framing_err = 1. Line held low for a whole frame -> data_out = 0x00, break_det = 1, framing_err = 1.
- data_ready held low across two back-to-back frames 0x11 then 0x22 -> data_out stays 0x11, overrun_err pulses once. Asserting ready on the second commit edge instead -> data_out = 0x22, data_valid never drops.
- rst_n asserted mid-DATA -> all outputs 0 immediately. A fresh 0x3C after reset is received correctly. DATA_BITS=5 with 0x1F -> data_out = 5'h1F.
